// File: rtl/tex_line_streamer_if.sv
// Bundles the character stream, the shared ROM port and the line-mapper lookup
// of tex_line_streamer; master is the streamer, slave is its environment.
interface tex_line_streamer_if #(
   parameter int NUM_CH = 2,
   parameter int WORD_W = 16,
   parameter int ADDR_W = 8,
   parameter int LINE_W = 6,
   parameter int LEN_W  = 8
);
   logic [NUM_CH*8-1:0]      char_o;
   logic [NUM_CH-1:0]        char_valid_o;
   logic [NUM_CH-1:0]        char_ready_i;
   logic [ADDR_W-1:0]        mem_addr_o;
   logic [WORD_W-1:0]        mem_dout_i;
   logic [LINE_W-1:0]        map_line_o;
   logic [NUM_CH*ADDR_W-1:0] map_base_i;
   logic [NUM_CH*LEN_W-1:0]  map_len_i;

   modport master (
      output char_o, char_valid_o, mem_addr_o, map_line_o,
      input  char_ready_i, mem_dout_i, map_base_i, map_len_i
   );

   modport slave (
      input  char_o, char_valid_o, mem_addr_o, map_line_o,
      output char_ready_i, mem_dout_i, map_base_i, map_len_i
   );
endinterface

// File: rtl/tex_line_streamer.sv
// Streams the packed-ASCII strings of one line on NUM_CH paced byte channels,
// sharing a single synchronous ROM port through a round-robin fetch engine.
module tex_line_streamer #(
   parameter int NUM_CH = 2,
   parameter int WORD_W = 16,
   parameter int ADDR_W = 8,
   parameter int LINE_W = 6,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LINE_W-1:0] line_i,
   input  logic              start_i,
   input  logic              loop_i,
   input  logic [1:0]        rate_sel_i,
   output logic              busy_o,
   output logic              done_o,
   tex_line_streamer_if.master bus
);

   localparam int CPW   = WORD_W / 8;
   localparam int CNT_W = $clog2(CPW + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic F_IDLE = 1'b0;
   localparam logic F_WAIT = 1'b1;

   logic [1:0]        state_q;
   logic              fstate_q;
   logic [LINE_W-1:0] line_q;
   logic              loop_q;
   logic              reload_q;
   logic [1:0]        rate_q;
   logic [15:0]       tick_cnt_q;
   logic [CH_W-1:0]   rr_q;
   logic [CH_W-1:0]   fch_q;

   logic [ADDR_W-1:0] base_q  [NUM_CH];
   logic [ADDR_W-1:0] widx_q  [NUM_CH];
   logic [LEN_W-1:0]  rem_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [WORD_W-1:0] buf_q   [NUM_CH];
   logic [7:0]        char_q  [NUM_CH];
   logic [NUM_CH-1:0] valid_q;

   logic              run;
   logic              tick;
   logic              grant;
   logic [CH_W-1:0]   grant_ch;
   logic              all_finished;
   logic [NUM_CH-1:0] finished;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] nul_hit;
   logic [NUM_CH-1:0] load_ch;
   logic [NUM_CH-1:0] xfer;
   logic [NUM_CH-1:0] capture;

   assign run    = (state_q == S_RUN);
   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);

   // On a first start the mapper must see the incoming line during LOAD;
   // on a loop restart it keeps seeing the latched one.
   assign bus.map_line_o   = (state_q == S_LOAD && !reload_q) ? line_i : line_q;
   assign bus.char_valid_o = valid_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      bus.char_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         bus.char_o[c*8 +: 8] = char_q[c];
      end
   end

   always_comb begin
      tick = 1'b1;
      case (rate_q)
         2'd0:    tick = 1'b1;
         2'd1:    tick = (tick_cnt_q[3:0] == '0);
         2'd2:    tick = (tick_cnt_q[7:0] == '0);
         default: tick = (tick_cnt_q == '0);
      endcase
   end

   // A channel needs a word when it still owes characters and its buffer is
   // drained; a NUL at the buffer head retires it without waiting for a tick.
   always_comb begin
      finished = '0;
      req      = '0;
      nul_hit  = '0;
      load_ch  = '0;
      xfer     = '0;
      capture  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         finished[c] = (rem_q[c] == '0);
         req[c]      = run && !finished[c] && (cnt_q[c] == '0);
         nul_hit[c]  = run && !finished[c] && (cnt_q[c] != '0) &&
                       (buf_q[c][WORD_W-1 -: 8] == 8'h00);
         xfer[c]     = valid_q[c] && bus.char_ready_i[c];
         load_ch[c]  = run && tick && !finished[c] && (cnt_q[c] != '0) &&
                       !nul_hit[c] && (!valid_q[c] || bus.char_ready_i[c]);
         capture[c]  = (fstate_q == F_WAIT) && (fch_q == CH_W'(c));
      end
   end

   assign all_finished = (&finished) && !(|valid_q) && (fstate_q == F_IDLE);

   always_comb begin
      int idx;
      idx      = 0;
      grant    = 1'b0;
      grant_ch = '0;
      if (fstate_q == F_IDLE) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant && req[idx]) begin
               grant    = 1'b1;
               grant_ch = CH_W'(idx);
            end
         end
      end
   end

   assign bus.mem_addr_o = grant ? (base_q[grant_ch] + widx_q[grant_ch]) : '0;

   // Main sequencer, fetch engine and pacing counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= S_IDLE;
         fstate_q   <= F_IDLE;
         line_q     <= '0;
         loop_q     <= 1'b0;
         reload_q   <= 1'b0;
         rate_q     <= '0;
         tick_cnt_q <= '0;
         rr_q       <= '0;
         fch_q      <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 16'd1;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q  <= S_LOAD;
                  reload_q <= 1'b0;
               end
            end
            S_LOAD: begin
               if (!reload_q) begin
                  line_q <= line_i;
                  loop_q <= loop_i;
                  rate_q <= rate_sel_i;
               end
               tick_cnt_q <= '0;
               rr_q       <= '0;
               fstate_q   <= F_IDLE;
               state_q    <= S_RUN;
            end
            S_RUN: begin
               if (fstate_q == F_WAIT) begin
                  fstate_q <= F_IDLE;
               end else if (grant) begin
                  fstate_q <= F_WAIT;
                  fch_q    <= grant_ch;
                  rr_q     <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
               end
               if (all_finished) state_q <= S_DONE;
            end
            default: begin
               state_q  <= loop_q ? S_LOAD : S_IDLE;
               reload_q <= loop_q;
            end
         endcase
      end
   end

   // Per-channel bookkeeping and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            base_q[c] <= '0;
            widx_q[c] <= '0;
            rem_q[c]  <= '0;
            cnt_q[c]  <= '0;
            char_q[c] <= '0;
         end
         valid_q <= '0;
      end else if (state_q == S_LOAD) begin
         for (int c = 0; c < NUM_CH; c++) begin
            base_q[c] <= bus.map_base_i[c*ADDR_W +: ADDR_W];
            rem_q[c]  <= bus.map_len_i[c*LEN_W +: LEN_W];
            widx_q[c] <= '0;
            cnt_q[c]  <= '0;
            char_q[c] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (capture[c]) begin
               cnt_q[c]  <= CNT_W'(CPW);
               widx_q[c] <= widx_q[c] + ADDR_W'(1);
            end
            if (nul_hit[c]) begin
               rem_q[c] <= '0;
               cnt_q[c] <= '0;
            end else if (load_ch[c]) begin
               char_q[c]  <= buf_q[c][WORD_W-1 -: 8];
               valid_q[c] <= 1'b1;
               rem_q[c]   <= rem_q[c] - LEN_W'(1);
               // Characters past len in the last word are dropped here.
               cnt_q[c]   <= (rem_q[c] == LEN_W'(1)) ? '0 : cnt_q[c] - CNT_W'(1);
            end
            if (!load_ch[c] && xfer[c]) begin
               valid_q[c] <= 1'b0;
               char_q[c]  <= '0;
            end
         end
      end
   end

   // NOTE: word buffer contents are not reset; cnt_q gates every use, so only the count needs clearing.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (capture[c]) begin
            buf_q[c] <= bus.mem_dout_i;
         end else if (load_ch[c]) begin
            buf_q[c] <= buf_q[c] << 8;
         end
      end
   end

endmodule

// File: tb/tb_tex_line_streamer.sv
// Directed bench for tex_line_streamer: a string-level model builds each
// channel's expected bytes, and one negedge process checks every cycle.
module tb_tex_line_streamer;

   localparam int NUM_CH = 2;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 8;
   localparam int LINE_W = 6;
   localparam int LEN_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [LINE_W-1:0] line_i = '0;
   logic              start_i = 1'b0;
   logic              loop_i = 1'b0;
   logic [1:0]        rate_sel_i = '0;
   logic              busy_o;
   logic              done_o;

   tex_line_streamer_if #(
      .NUM_CH(NUM_CH), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LEN_W(LEN_W)
   ) bus ();

   tex_line_streamer #(
      .NUM_CH(NUM_CH), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LEN_W(LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .start_i   (start_i),
      .loop_i    (loop_i),
      .rate_sel_i(rate_sel_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Environment: synchronous ROM and a table-driven line mapper.
   logic [15:0] rom [256];
   logic [7:0]  mb0 [64];
   logic [7:0]  mb1 [64];
   logic [7:0]  ml0 [64];
   logic [7:0]  ml1 [64];

   always @(posedge clk) bus.mem_dout_i <= rom[bus.mem_addr_o];

   always_comb begin
      bus.map_base_i = {mb1[bus.map_line_o], mb0[bus.map_line_o]};
      bus.map_len_i  = {ml1[bus.map_line_o], ml0[bus.map_line_o]};
   end

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int valid_cycles [NUM_CH];
   int last_load [NUM_CH];
   int cur_rate = 0;
   logic [7:0] exp_q0 [$];
   logic [7:0] exp_q1 [$];
   bit   pv [NUM_CH];
   bit   pxr [NUM_CH];
   logic [7:0] pch [NUM_CH];

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // String-level model: walk the packed words byte by byte until len or NUL.
   task automatic model_push(input int c, input logic [7:0] base, input logic [7:0] len);
      for (int n = 0; n < int'(len); n++) begin
         logic [15:0] w;
         logic [7:0]  b;
         w = rom[(int'(base) + n / 2) % 256];
         b = (n % 2 == 0) ? w[15:8] : w[7:0];
         if (b == 8'h00) break;
         if (c == 0) exp_q0.push_back(b);
         else        exp_q1.push_back(b);
      end
   endtask

   task automatic model_line(input int line);
      model_push(0, mb0[line], ml0[line]);
      model_push(1, mb1[line], ml1[line]);
   endtask

   task automatic start_run(input int line, input bit lp, input int rate);
      @(posedge clk); #1;
      line_i     = LINE_W'(line);
      loop_i     = lp;
      rate_sel_i = 2'(rate);
      cur_rate   = rate;
      start_i    = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done_o) seen = 1'b1;
      end
      check(seen, name, int'(seen), 1);
   endtask

   // Per-cycle compare process.
   always @(negedge clk) begin
      cyc++;
      if (done_o) done_cnt++;
      for (int c = 0; c < NUM_CH; c++) begin
         logic       v;
         logic       r;
         logic [7:0] ch;
         logic [7:0] e;
         bit         have;
         v  = bus.char_valid_o[c];
         r  = bus.char_ready_i[c];
         ch = bus.char_o[c*8 +: 8];
         if (rst) begin
            pv[c]  = 1'b0;
            pxr[c] = 1'b0;
         end else begin
            if (v) valid_cycles[c]++;
            if (!v) check(ch == 8'h00, "idle_char_zero", ch, 0);
            if (pv[c] && !pxr[c]) begin
               check(v, "valid_held_under_stall", int'(v), 1);
               check(ch == pch[c], "char_stable_under_stall", ch, pch[c]);
            end
            if (v && (!pv[c] || pxr[c])) begin
               if (cur_rate == 1 && last_load[c] >= 0)
                  check(cyc - last_load[c] >= 16, "pace_gap", cyc - last_load[c], 16);
               last_load[c] = cyc;
            end
            if (v && r) begin
               have = (c == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
               check(have, "char_expected", ch, 0);
               if (have) begin
                  if (c == 0) e = exp_q0.pop_front();
                  else        e = exp_q1.pop_front();
                  check(ch == e, "char_data", ch, e);
               end
            end
            pv[c]  = v;
            pxr[c] = v && r;
            pch[c] = ch;
         end
      end
   end

   initial begin
      int d0;
      int vc1;
      bit seen;
      for (int i = 0; i < 256; i++) rom[i] = 16'hEEEE;
      for (int i = 0; i < 64; i++) begin
         mb0[i] = 8'h00; mb1[i] = 8'h00; ml0[i] = 8'h00; ml1[i] = 8'h00;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         valid_cycles[c] = 0;
         last_load[c]    = -1;
         pv[c] = 1'b0; pxr[c] = 1'b0; pch[c] = 8'h00;
      end
      bus.char_ready_i = 2'b11;

      // Line table.
      rom[8'h10] = 16'h5C66; rom[8'h11] = 16'h2874; rom[8'h20] = 16'h3173;
      mb0[1] = 8'h10; ml0[1] = 8'd3; mb1[1] = 8'h20; ml1[1] = 8'd2;
      rom[8'h30] = 16'h4100;
      mb0[2] = 8'h30; ml0[2] = 8'd5; mb1[2] = 8'h40; ml1[2] = 8'd0;
      rom[8'h50] = 16'h4142; rom[8'h51] = 16'h4344; rom[8'h60] = 16'h6162; rom[8'h61] = 16'h6364;
      mb0[3] = 8'h50; ml0[3] = 8'd4; mb1[3] = 8'h60; ml1[3] = 8'd4;
      rom[8'hFF] = 16'h5758; rom[8'h00] = 16'h595A; rom[8'h70] = 16'h3132; rom[8'h71] = 16'h3300;
      mb0[4] = 8'hFF; ml0[4] = 8'd4; mb1[4] = 8'h70; ml1[4] = 8'd3;
      rom[8'h80] = 16'h4C4F; rom[8'h81] = 16'h4F50; rom[8'h90] = 16'h2100;
      mb0[5] = 8'h80; ml0[5] = 8'd3; mb1[5] = 8'h90; ml1[5] = 8'd1;
      rom[8'hA0] = 16'h5A5A;
      mb0[6] = 8'hA0; ml0[6] = 8'd2; mb1[6] = 8'hA0; ml1[6] = 8'd2;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(bus.char_valid_o == '0, "rst_valid", bus.char_valid_o, 0);
      check(bus.char_o == '0, "rst_char", bus.char_o, 0);
      check(bus.mem_addr_o == '0, "rst_addr", bus.mem_addr_o, 0);
      check(bus.map_line_o == '0, "rst_map_line", bus.map_line_o, 0);
      check(!busy_o, "rst_busy", busy_o, 0);
      check(!done_o, "rst_done", done_o, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Basic stream.
      model_line(1);
      check(exp_q0.size() == 3 && exp_q0[0] == 8'h5C && exp_q0[1] == 8'h66 && exp_q0[2] == 8'h28,
            "model_basic_ch0", exp_q0.size(), 3);
      check(exp_q1.size() == 2 && exp_q1[0] == 8'h31 && exp_q1[1] == 8'h73,
            "model_basic_ch1", exp_q1.size(), 2);
      d0 = done_cnt;
      start_run(1, 1'b0, 0);
      wait_done(200, "basic_done");
      @(negedge clk);
      check(!busy_o, "basic_idle_after_done", busy_o, 0);
      repeat (3) @(negedge clk);
      check(done_cnt - d0 == 1, "basic_one_done_pulse", done_cnt - d0, 1);
      check(exp_q0.size() == 0 && exp_q1.size() == 0, "basic_all_emitted",
            exp_q0.size() + exp_q1.size(), 0);

      // NUL termination and empty channel.
      model_line(2);
      check(exp_q0.size() == 1 && exp_q0[0] == 8'h41, "model_nul_ch0", exp_q0.size(), 1);
      vc1 = valid_cycles[1];
      start_run(2, 1'b0, 0);
      wait_done(200, "nul_done");
      repeat (2) @(negedge clk);
      check(exp_q0.size() == 0, "nul_ch0_emitted", exp_q0.size(), 0);
      check(valid_cycles[1] == vc1, "empty_ch1_never_valid", valid_cycles[1] - vc1, 0);

      // Backpressure on ch0 while ch1 keeps streaming.
      model_line(3);
      bus.char_ready_i = 2'b10;
      start_run(3, 1'b0, 0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (bus.char_valid_o[0]) seen = 1'b1;
      end
      check(seen, "bp_ch0_valid", int'(seen), 1);
      repeat (12) @(negedge clk);
      check(bus.char_valid_o[0] && bus.char_o[7:0] == 8'h41, "bp_ch0_holding", bus.char_o[7:0], 8'h41);
      check(exp_q1.size() == 0, "bp_ch1_streamed", exp_q1.size(), 0);
      @(posedge clk); #1 bus.char_ready_i = 2'b11;
      wait_done(200, "bp_done");
      repeat (2) @(negedge clk);
      check(exp_q0.size() == 0, "bp_ch0_no_loss", exp_q0.size(), 0);

      // Pacing at rate 1 and address wrap.
      model_line(4);
      check(exp_q0.size() == 4 && exp_q0[2] == 8'h59 && exp_q0[3] == 8'h5A, "model_wrap_ch0",
            exp_q0.size(), 4);
      check(exp_q1.size() == 3, "model_wrap_ch1", exp_q1.size(), 3);
      start_run(4, 1'b0, 1);
      wait_done(600, "pace_done");
      repeat (2) @(negedge clk);
      check(exp_q0.size() == 0 && exp_q1.size() == 0, "pace_all_emitted",
            exp_q0.size() + exp_q1.size(), 0);
      cur_rate = 0;

      // Loop mode; a mid-run line change and start request must not matter.
      model_line(5); model_line(5); model_line(5);
      d0 = done_cnt;
      start_run(5, 1'b1, 0);
      wait_done(200, "loop_done_1");
      @(posedge clk); #1;
      line_i  = 6'd6;
      start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      @(negedge clk);
      check(bus.map_line_o == 6'd5, "loop_line_latched", bus.map_line_o, 5);
      wait_done(200, "loop_done_2");
      wait_done(200, "loop_done_3");
      @(posedge clk); #1;
      rst    = 1'b1;
      loop_i = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check(done_cnt - d0 == 3, "loop_three_pulses", done_cnt - d0, 3);
      check(exp_q0.size() == 0 && exp_q1.size() == 0, "loop_repeats_exact",
            exp_q0.size() + exp_q1.size(), 0);

      // Reset in the middle of a stalled ch0 transfer, then restart.
      model_line(1);
      bus.char_ready_i = 2'b10;
      start_run(1, 1'b0, 0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (bus.char_valid_o[0]) seen = 1'b1;
      end
      check(seen, "mid_rst_ch0_valid", int'(seen), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check(bus.char_valid_o == '0, "mid_rst_valid", bus.char_valid_o, 0);
      check(!busy_o, "mid_rst_busy", busy_o, 0);
      check(!done_o, "mid_rst_done", done_o, 0);
      bus.char_ready_i = 2'b11;
      model_line(1);
      start_run(1, 1'b0, 0);
      wait_done(200, "restart_done");
      repeat (2) @(negedge clk);
      check(exp_q0.size() == 0 && exp_q1.size() == 0, "restart_all_emitted",
            exp_q0.size() + exp_q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
